// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iterative
//  Description : Multi-cycle radix-2 multiply/divide unit with HI/LO result
//                registers. Signed operations run on magnitudes; the signs
//                are corrected in a single FIX cycle before the commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iterative #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_prod;     // product, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opb;      // multiplicand / divisor magnitude
    logic               r_is_div;
    logic               r_neg_res;  // negate product / quotient at FIX
    logic               r_neg_rem;  // negate remainder at FIX
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes and one radix-2 step for each datapath.
    // Low half of r_prod holds the multiplier (shifted out LSB first) or the
    // dividend (shifted out MSB first while quotient bits shift in).
    always_comb begin
        w_signed   = (op == c_op_mult) || (op == c_op_div);
        w_mag_a    = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        w_mag_b    = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

        w_add      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
        w_mul_next = r_prod[0] ? {w_add, r_prod[WIDTH-1:1]}
                               : {1'b0, r_prod[2*WIDTH-1:1]};

        // Restoring step: remainder stays below the divisor, so it fits the
        // upper WIDTH bits; bit WIDTH of the difference is the borrow.
        w_shift    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_opb};
        w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};

        w_prod_fix = r_neg_res ? -r_prod : r_prod;
        w_quo_fix  = r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
        w_rem_fix  = r_neg_rem ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO commit; flush beats start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            case (op)
                                c_op_mthi: r_hi <= src_a;
                                c_op_mtlo: r_lo <= src_a;
                                c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
                                    if (op[1] && (src_b == '0)) begin
                                        r_done <= 1'b1;
                                        r_dbz  <= 1'b1;
                                    end else begin
                                        r_prod    <= {{WIDTH{1'b0}}, w_mag_a};
                                        r_opb     <= w_mag_b;
                                        r_is_div  <= op[1];
                                        r_neg_res <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                                        r_neg_rem <= w_signed & src_a[WIDTH-1];
                                        r_cnt     <= CNT_W'(WIDTH);
                                        r_busy    <= 1'b1;
                                        r_state   <= S_RUN;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_RUN: begin
                        r_prod <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_iterative
//  Description : Self-checking bench for mdu_iterative (WIDTH=32): vector
//                table for the arithmetic plus directed control sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iterative;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request so the next rising edge samples it; returns at the
    // falling edge right after that start edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic fl);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
    endtask

    // Count busy samples until done, bounded.
    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    // Watch a number of cycles and return how many had done high.
    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    initial begin
        int  nb;
        int  nd;
        bit  ok;

        vecs[0] = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{3'd1, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
        vecs[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
        vecs[8] = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[9] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_flags", {61'h0, busy, done, div_by_zero}, 64'h0);

        // Arithmetic vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_done(nb, ok);
            chk($sformatf("v%0d_done", i), 64'(ok), 64'h1);
            chk($sformatf("v%0d_busycycles", i), 64'(nb), 64'd33);
            chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("v%0d_flags_at_done", i), {62'h0, busy, div_by_zero}, 64'h0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
        end

        // MTHI / MTLO, ignored op 6, then divide by zero
        issue(3'd4, 32'h1234, 32'h0, 1'b0);
        chk("mthi_nobusy", {62'h0, busy, done}, 64'h0);
        issue(3'd5, 32'h5678, 32'h0, 1'b0);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mtlo_lo", 64'(lo), 64'h5678);
        issue(3'd6, 32'hDEAD, 32'hBEEF, 1'b0);
        chk("op6_ignored", {busy, done, hi, lo}, {2'b00, 32'h1234, 32'h5678});
        issue(3'd2, 32'd55, 32'd0, 1'b0);
        chk("dbz_flags", {61'h0, busy, done, div_by_zero}, 64'h3);
        chk("dbz_hilo", {hi, lo}, {32'h1234, 32'h5678});
        @(negedge clk);
        chk("dbz_pulse", {62'h0, done, div_by_zero}, 64'h0);

        // Flush at edge 10 of a DIVU, stray start at edge 5 first
        issue(3'd3, 32'd100, 32'd7, 1'b0);        // edge 0
        nd = 0;
        repeat (4) begin @(negedge clk); if (done) nd++; end  // after edge 4
        start = 1'b1; op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(negedge clk); if (done) nd++;           // after edge 5
        start = 1'b0;
        repeat (4) begin @(negedge clk); if (done) nd++; end  // after edge 9
        flush = 1'b1;
        @(negedge clk);                           // after edge 10
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'h0);
        chk("flush_hilo", {hi, lo}, {32'h1234, 32'h5678});
        count_done(40, nb);
        chk("flush_no_done", 64'(nd + nb), 64'h0);

        // Stray start while busy on an operation that completes
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, ok);
        chk("stray_done", 64'(ok), 64'h1);
        chk("stray_hilo", {hi, lo}, {32'd2, 32'd14});
        count_done(40, nd);
        chk("stray_single_done", 64'(nd), 64'h0);

        // Reset asserted at edge 20 of a MULT
        issue(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);   // edge 0
        repeat (19) @(negedge clk);               // after edge 19
        reset = 1'b0;
        @(negedge clk);                           // edge 20 resets
        reset = 1'b1;
        chk("midrst_hilo", {hi, lo}, 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        count_done(40, nd);
        chk("midrst_no_done", 64'(nd), 64'h0);

        // start+flush together: MTLO must not write
        issue(3'd5, 32'hAA, 32'h0, 1'b1);
        chk("flush_start_lo", 64'(lo), 64'h0);
        issue(3'd5, 32'hAA, 32'h0, 1'b0);
        chk("mtlo_after", 64'(lo), 64'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
